// File: rtl/video_timing_pkg.sv
// Shared types for the video timing receiver: coordinate width, lock FSM states
// and the per-frame measurement record.
package video_timing_pkg;

  localparam int COORD_W = 12;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH,
    ACQ,
    LOCK
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] h_active;
    logic [COORD_W-1:0] h_total;
    logic [COORD_W-1:0] v_active;
    logic [COORD_W-1:0] v_total;
  } meas_t;

  // Counters hold at full scale instead of wrapping.
  function automatic logic [COORD_W-1:0] satInc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one incoming sync line, folds in its polarity and reports the
// asserted level together with one-cycle leading/trailing edge pulses.
module sync_edge_det #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic level_o,
  output logic lead_o,
  output logic trail_o
);

  logic sig_q;
  logic prevLevel_q;

  // Reset to the inactive level so no edge is reported out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q       <= ~POL;
      prevLevel_q <= 1'b0;
    end else begin
      sig_q       <= sig_i;
      prevLevel_q <= level_o;
    end
  end

  assign level_o = (sig_q == POL);
  assign lead_o  = level_o & ~prevLevel_q;
  assign trail_o = ~level_o & prevLevel_q;

endmodule

// File: rtl/video_timing_rx.sv
// Recovers raster coordinates, per-frame format measurements and a lock flag
// from an hs/vs/de stream. Optional format check: define TIMING_CHECK_EN.
module video_timing_rx
  import video_timing_pkg::*;
#(
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  parameter logic [2:0]  LOCK_FRAMES = 3'd3,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
`ifdef TIMING_CHECK_EN
  ,
  parameter logic [11:0] EXP_H_ACTIVE = 12'd480,
  parameter logic [11:0] EXP_V_ACTIVE = 12'd272
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               de_in,
  output logic               pix_vld,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_start,
  output logic [COORD_W-1:0] meas_h_active,
  output logic [COORD_W-1:0] meas_h_total,
  output logic [COORD_W-1:0] meas_v_active,
  output logic [COORD_W-1:0] meas_v_total,
  output logic               meas_upd,
  output logic               locked,
  output logic               fmt_err
);

  localparam logic [2:0] LOCK_TARGET = LOCK_FRAMES - 3'd1;

  logic hsLevel, hsLead, hsTrail;
  logic vsLevel, vsLead, vsTrail;
  logic deLevel, deLead, deTrail;
  logic unusedSync;

  sync_edge_det #(.POL(HS_POL)) uHs (.clk(clk), .rst_n(rst_n), .sig_i(hs_in),
    .level_o(hsLevel), .lead_o(hsLead), .trail_o(hsTrail));
  sync_edge_det #(.POL(VS_POL)) uVs (.clk(clk), .rst_n(rst_n), .sig_i(vs_in),
    .level_o(vsLevel), .lead_o(vsLead), .trail_o(vsTrail));
  sync_edge_det #(.POL(1'b1)) uDe (.clk(clk), .rst_n(rst_n), .sig_i(de_in),
    .level_o(deLevel), .lead_o(deLead), .trail_o(deTrail));

  assign unusedSync = &{1'b0, hsLevel, hsTrail, vsLevel, vsTrail};

  logic [COORD_W-1:0] hAct_q, hAct_d, hCnt_q, hCnt_d, hTot_q, hTot_d;
  logic [COORD_W-1:0] vAct_q, vAct_d, vTot_q, vTot_d, firstW_q, firstW_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic               incons_q, incons_d, pixVld_q, frameStart_q;
  logic [23:0]        toCnt_q, toCnt_d;
  meas_t              meas_q, meas_d, frameMeas;
  logic               measUpd_q, measUpd_d;
  state_t             state_q, state_d;
  logic [2:0]         stab_q, stab_d, stabInc;
  logic               prevOk_q, prevOk_d;
  logic               lineBad, frameOk, frameMatch;

  // A line closing in the same cycle as vs still belongs to the finishing frame.
  assign lineBad   = deTrail && (vAct_q != '0) && (hAct_q != firstW_q);
  assign frameOk   = ~incons_q & ~lineBad;
  assign frameMeas = '{h_active: hAct_q, h_total: hTot_q,
                       v_active: deTrail ? satInc(vAct_q) : vAct_q, v_total: vTot_q};
  assign frameMatch = frameOk && prevOk_q && (frameMeas == meas_q);
  assign stabInc   = stab_q + 3'd1;

  always_comb begin
    hAct_d   = hAct_q;
    hCnt_d   = satInc(hCnt_q);
    hTot_d   = hTot_q;
    vAct_d   = vAct_q;
    vTot_d   = vTot_q;
    firstW_d = firstW_q;
    incons_d = incons_q;
    x_d      = x_q;
    if (deLead) begin
      hAct_d = 12'd1;
      x_d    = '0;
    end else if (deLevel) begin
      hAct_d = satInc(hAct_q);
      x_d    = satInc(x_q);
    end
    if (hsLead) begin
      hCnt_d = 12'd1;
      hTot_d = hCnt_q;
      vTot_d = satInc(vTot_q);
    end
    if (deTrail) begin
      vAct_d = satInc(vAct_q);
      if (vAct_q == '0) firstW_d = hAct_q;
      else if (lineBad) incons_d = 1'b1;
    end
    if (vsLead) begin
      vAct_d   = '0;
      vTot_d   = hsLead ? 12'd1 : 12'd0;
      incons_d = 1'b0;
    end
  end

  // The frame after reset or a timeout only seeds the comparison reference.
  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    prevOk_d  = prevOk_q;
    meas_d    = meas_q;
    measUpd_d = 1'b0;
    toCnt_d   = (toCnt_q == TIMEOUT_CYC) ? toCnt_q : toCnt_q + 24'd1;
    if (vsLead) begin
      toCnt_d = '0;
      if (state_q == SEARCH) begin
        state_d = ACQ;
      end else if (vTot_q != '0) begin
        measUpd_d = 1'b1;
        meas_d    = frameMeas;
        prevOk_d  = frameOk;
        if (!frameMatch) begin
          stab_d  = '0;
          state_d = ACQ;
        end else if (state_q == ACQ) begin
          stab_d = stabInc;
          if (stabInc >= LOCK_TARGET) state_d = LOCK;
        end
      end
    end else if (toCnt_q == TIMEOUT_CYC) begin
      state_d  = SEARCH;
      stab_d   = '0;
      prevOk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hAct_q       <= '0;
      hCnt_q       <= '0;
      hTot_q       <= '0;
      vAct_q       <= '0;
      vTot_q       <= '0;
      firstW_q     <= '0;
      incons_q     <= 1'b0;
      x_q          <= '0;
      pixVld_q     <= 1'b0;
      frameStart_q <= 1'b0;
      toCnt_q      <= '0;
      meas_q       <= '0;
      measUpd_q    <= 1'b0;
      state_q      <= SEARCH;
      stab_q       <= '0;
      prevOk_q     <= 1'b0;
    end else begin
      hAct_q       <= hAct_d;
      hCnt_q       <= hCnt_d;
      hTot_q       <= hTot_d;
      vAct_q       <= vAct_d;
      vTot_q       <= vTot_d;
      firstW_q     <= firstW_d;
      incons_q     <= incons_d;
      x_q          <= x_d;
      pixVld_q     <= deLevel;
      frameStart_q <= deLead && (vAct_d == '0);
      toCnt_q      <= toCnt_d;
      meas_q       <= meas_d;
      measUpd_q    <= measUpd_d;
      state_q      <= state_d;
      stab_q       <= stab_d;
      prevOk_q     <= prevOk_d;
    end
  end

`ifdef TIMING_CHECK_EN
  logic fmtErr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) fmtErr_q <= 1'b0;
    else if (measUpd_d)
      fmtErr_q <= (meas_d.h_active != EXP_H_ACTIVE) || (meas_d.v_active != EXP_V_ACTIVE);
  end

  assign fmt_err = fmtErr_q;
`else
  assign fmt_err = 1'b0;
`endif

  assign pix_vld       = pixVld_q;
  assign x             = x_q;
  assign y             = vAct_q;
  assign frame_start   = frameStart_q;
  assign meas_h_active = meas_q.h_active;
  assign meas_h_total  = meas_q.h_total;
  assign meas_v_active = meas_q.v_active;
  assign meas_v_total  = meas_q.v_total;
  assign meas_upd      = measUpd_q;
  assign locked        = (state_q == LOCK);

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx on a small 8x5 raster (12x8 total) with a
// short timeout, covering lock, inconsistent line, timeout and mid-line reset.
module tb_video_timing_rx;
  import video_timing_pkg::*;

  localparam int H_ACT = 8, H_TOT = 12, V_ACT = 5, V_TOT = 8, VS_ROW = 6;
  localparam int FRAME_CYC   = H_TOT * V_TOT;
  localparam int VS_LEAD_IDX = VS_ROW * H_TOT;
  localparam int TO_CYC      = 200;
`ifdef TIMING_CHECK_EN
  localparam logic EXP_FMT = 1'b1;
`else
  localparam logic EXP_FMT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, hs_in, vs_in, de_in;
  logic pix_vld, frame_start, meas_upd, locked, fmt_err;
  logic [11:0] x, y, meas_h_active, meas_h_total, meas_v_active, meas_v_total;

  video_timing_rx #(
    .TIMEOUT_CYC(24'(TO_CYC))
`ifdef TIMING_CHECK_EN
    , .EXP_V_ACTIVE(12'd6)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .pix_vld(pix_vld), .x(x), .y(y), .frame_start(frame_start),
    .meas_h_active(meas_h_active), .meas_h_total(meas_h_total),
    .meas_v_active(meas_v_active), .meas_v_total(meas_v_total),
    .meas_upd(meas_upd), .locked(locked), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic chkEn = 1'b0;
  logic de1 = 1'b0, de2 = 1'b0, lead1 = 1'b0, lead2 = 1'b0;
  int x1 = 0, x2 = 0, y1 = 0, y2 = 0;
  int updCount, lastX, lastY;
  logic updAtLead, lockedAtUpd, lockedBeforeUpd, lastLocked = 1'b0, fmtAtUpd;
  logic [11:0] capHA, capHT, capVA, capVT;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock: sample outputs just after the edge, compare with inputs driven two steps earlier, drive next.
  task automatic applyStimulus(input logic de, input logic hs, input logic vs,
                               input int c, input int r, input logic isLead);
    @(posedge clk);
    #1;
    if (chkEn) begin
      checkOutput("pix_vld", pix_vld, de2);
      if (de2) begin
        checkOutput("x", x, x2);
        checkOutput("y", y, y2);
      end
      checkOutput("frame_start", frame_start, de2 && x2 == 0 && y2 == 0);
    end
    if (lead2) updAtLead = meas_upd;
    if (meas_upd) begin
      updCount++;
      lockedAtUpd = locked;
      lockedBeforeUpd = lastLocked;
      fmtAtUpd = fmt_err;
      capHA = meas_h_active; capHT = meas_h_total;
      capVA = meas_v_active; capVT = meas_v_total;
    end
    if (pix_vld) begin
      lastX = int'(x);
      lastY = int'(y);
    end
    lastLocked = locked;
    de2 = de1; x2 = x1; y2 = y1; lead2 = lead1;
    de1 = de;  x1 = c;  y1 = r;  lead1 = isLead;
    de_in = de; hs_in = hs; vs_in = vs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
  endtask

  // hs pulses low at columns 9..10, vs low over rows 6..7; badRow gets a one-pixel-short line.
  task automatic driveFrame(input int badRow, input int nSteps);
    int r, c, w;
    updCount = 0; updAtLead = 1'b0; lastX = -1; lastY = -1;
    for (int i = 0; i < nSteps; i++) begin
      r = i / H_TOT;
      c = i % H_TOT;
      w = (r == badRow) ? H_ACT - 1 : H_ACT;
      applyStimulus((r < V_ACT) && (c < w), !(c >= 9 && c < 11), !(r >= VS_ROW),
                    c, r, i == VS_LEAD_IDX);
    end
  endtask

  task automatic checkFrame(input string tag, input logic expUpd,
                            input logic expLockedBefore, input logic expLockedAt);
    checkOutput({tag, " meas_upd count"}, updCount, {31'd0, expUpd});
    checkOutput({tag, " last x"}, lastX, H_ACT - 1);
    checkOutput({tag, " last y"}, lastY, V_ACT - 1);
    if (expUpd) begin
      checkOutput({tag, " meas_upd at vs+2"}, updAtLead, 1);
      checkOutput({tag, " locked before upd"}, lockedBeforeUpd, expLockedBefore);
      checkOutput({tag, " locked at upd"}, lockedAtUpd, expLockedAt);
      checkOutput({tag, " h_active"}, capHA, H_ACT);
      checkOutput({tag, " h_total"}, capHT, H_TOT);
      checkOutput({tag, " v_active"}, capVA, V_ACT);
      checkOutput({tag, " v_total"}, capVT, V_TOT);
      checkOutput({tag, " fmt_err"}, fmtAtUpd, EXP_FMT);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " pix_vld"}, pix_vld, 0);
    checkOutput({tag, " x"}, x, 0);
    checkOutput({tag, " y"}, y, 0);
    checkOutput({tag, " frame_start"}, frame_start, 0);
    checkOutput({tag, " meas_h_active"}, meas_h_active, 0);
    checkOutput({tag, " meas_h_total"}, meas_h_total, 0);
    checkOutput({tag, " meas_v_active"}, meas_v_active, 0);
    checkOutput({tag, " meas_v_total"}, meas_v_total, 0);
    checkOutput({tag, " meas_upd"}, meas_upd, 0);
    checkOutput({tag, " locked"}, locked, 0);
    checkOutput({tag, " fmt_err"}, fmt_err, 0);
    checkOutput({tag, " state"}, dut.state_q, SEARCH);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    idle(3);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    chkEn = 1'b1;
    idle(2);

    driveFrame(-1, FRAME_CYC); checkFrame("A", 1'b0, 1'b0, 1'b0);
    driveFrame(-1, FRAME_CYC); checkFrame("B", 1'b1, 1'b0, 1'b0);
    driveFrame(-1, FRAME_CYC); checkFrame("C", 1'b1, 1'b0, 1'b0);
    driveFrame(-1, FRAME_CYC); checkFrame("D", 1'b1, 1'b0, 1'b1);
    driveFrame(-1, FRAME_CYC); checkFrame("E", 1'b1, 1'b1, 1'b1);
    driveFrame(2,  FRAME_CYC); checkFrame("F short line", 1'b1, 1'b1, 1'b0);
    driveFrame(-1, FRAME_CYC); checkFrame("G", 1'b1, 1'b0, 1'b0);
    driveFrame(-1, FRAME_CYC); checkFrame("H", 1'b1, 1'b0, 1'b0);
    driveFrame(-1, FRAME_CYC); checkFrame("I relock", 1'b1, 1'b0, 1'b1);

    // Last vs lead was driven FRAME_CYC-1-VS_LEAD_IDX steps ago; lock drops TO_CYC+3 steps after it.
    idle(TO_CYC + 2 - (FRAME_CYC - 1 - VS_LEAD_IDX));
    checkOutput("locked before timeout", lastLocked, 1);
    idle(1);
    checkOutput("locked after timeout", lastLocked, 0);
    checkOutput("state after timeout", dut.state_q, SEARCH);

    driveFrame(-1, FRAME_CYC); checkFrame("J after timeout", 1'b0, 1'b0, 1'b0);
    driveFrame(-1, FRAME_CYC); checkFrame("K", 1'b1, 1'b0, 1'b0);

    driveFrame(-1, 2 * H_TOT + 4);
    chkEn = 1'b0;
    rst_n = 1'b0;
    idle(1);
    checkResetOutputs("mid-line reset");
    rst_n = 1'b1;
    idle(2);
    chkEn = 1'b1;
    driveFrame(-1, FRAME_CYC); checkFrame("M after reset", 1'b0, 1'b0, 1'b0);
    driveFrame(-1, FRAME_CYC); checkFrame("N", 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
